// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory-access state encoding and opcode class tests
// for the LC3 pipeline controller.
package lc3_ctrl_pkg;

  localparam logic [3:0] OpBr  = 4'd0;
  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpLd  = 4'd2;
  localparam logic [3:0] OpSt  = 4'd3;
  localparam logic [3:0] OpAnd = 4'd5;
  localparam logic [3:0] OpLdr = 4'd6;
  localparam logic [3:0] OpStr = 4'd7;
  localparam logic [3:0] OpNot = 4'd9;
  localparam logic [3:0] OpLdi = 4'd10;
  localparam logic [3:0] OpSti = 4'd11;
  localparam logic [3:0] OpJmp = 4'd12;
  localparam logic [3:0] OpLea = 4'd14;

  typedef enum logic [1:0] {
    MemRd   = 2'd0,
    MemInd  = 2'd1,
    MemWr   = 2'd2,
    MemIdle = 2'd3
  } mem_state_e;

  function automatic logic is_alu(logic [3:0] op);
    return op inside {OpAdd, OpAnd, OpNot, OpLea};
  endfunction

  function automatic logic is_load(logic [3:0] op);
    return op inside {OpLd, OpLdr, OpLdi};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {OpSt, OpStr, OpSti};
  endfunction

  function automatic logic is_ctrl(logic [3:0] op);
    return op inside {OpBr, OpJmp};
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_if.sv
// Controller <-> datapath bundle: stage instructions and memory handshakes in,
// stage enables, bypass selects and memory sequencing out.
interface lc3_pipe_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;
  logic        instrmem_rd;

  modport master (
    input  complete_instr, complete_data, IMem_dout, IR, IR_Exec, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    output mem_state, instrmem_rd
  );

  modport slave (
    output complete_instr, complete_data, IMem_dout, IR, IR_Exec, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    input  mem_state, instrmem_rd
  );
endinterface

// File: rtl/lc3_bypass_unit.sv
// Combinational operand forwarding: compares decode's source registers against
// the destination of the instruction sitting in execute's output register.
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic        en,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic [3:0] op;
  logic [3:0] op_exec;
  logic [2:0] dst;
  logic [2:0] sr2;
  logic       sr1_used;
  logic       sr2_used;
  logic       hit_1;
  logic       hit_2;

  always_comb begin
    op       = ir[15:12];
    op_exec  = ir_exec[15:12];
    dst      = ir_exec[11:9];
    // Stores read their data register from the dst field.
    sr2      = is_store(op) ? ir[11:9] : ir[2:0];
    sr1_used = op inside {OpAdd, OpAnd, OpNot, OpLdr, OpStr, OpJmp};
    sr2_used = is_store(op) || ((op == OpAdd || op == OpAnd) && !ir[5]);
    hit_1    = en && sr1_used && (ir[8:6] == dst);
    hit_2    = en && sr2_used && (sr2 == dst);
    bypass_alu_1 = hit_1 && is_alu(op_exec);
    bypass_alu_2 = hit_2 && is_alu(op_exec);
    bypass_mem_1 = hit_1 && is_load(op_exec);
    bypass_mem_2 = hit_2 && is_load(op_exec);
  end

  logic unused_fields;
  assign unused_fields = ^{ir[4:3], ir_exec[8:0]};

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 pipeline controller: startup ramp, branch bubbles, data-memory access
// sequencing and stage enables; forwarding lives in lc3_bypass_unit.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned BR_BUBBLES = 2
) (
  input logic                  clock,
  input logic                  reset,
  lc3_pipe_controller_if.master bus
);

  localparam logic [1:0] BrLoad = 2'(BR_BUBBLES + 1);

  mem_state_e state_q;
  logic [1:0] start_q;
  logic [1:0] br_q;
  logic       served_q;

  logic [3:0] op_exec;
  logic       gstall;
  logic       mem_start;
  logic       hold;
  logic       trigger;
  logic       en_pc, en_f, en_d, en_e, en_w;
  logic       br_taken;

  always_comb begin
    op_exec   = bus.IR_Exec[15:12];
    gstall    = (state_q == MemIdle) && !bus.complete_instr;
    mem_start = (state_q == MemIdle) && !served_q && (is_load(op_exec) || is_store(op_exec));
    hold      = gstall || mem_start || (state_q != MemIdle);

    en_pc = 1'b1;
    en_f  = 1'b1;
    en_d  = (start_q != 2'd0);
    en_e  = (start_q >= 2'd2);
    en_w  = (start_q == 2'd3);
    case (br_q)
      2'd3: begin
        en_pc = 1'b0;
        en_f  = 1'b0;
        en_d  = 1'b0;
        en_e  = 1'b1;
      end
      2'd2: begin
        en_f = 1'b0;
        en_d = 1'b0;
        en_e = 1'b0;
      end
      2'd1: begin
        en_d = 1'b1;
        en_e = 1'b0;
        en_w = 1'b0;
      end
      default: ;
    endcase
    if (hold) begin
      en_pc = 1'b0;
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_w  = 1'b0;
    end

    trigger  = en_f && bus.complete_instr && is_ctrl(bus.IMem_dout[15:12]);
    br_taken = !hold && (br_q == 2'd2) &&
               ((op_exec == OpJmp) || ((op_exec == OpBr) && |(bus.IR_Exec[11:9] & bus.psr)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MemIdle;
      start_q  <= 2'd0;
      br_q     <= 2'd0;
      served_q <= 1'b0;
    end else begin
      case (state_q)
        MemIdle: begin
          if (mem_start) begin
            if (op_exec == OpLdi || op_exec == OpSti) state_q <= MemInd;
            else if (is_load(op_exec))               state_q <= MemRd;
            else                                     state_q <= MemWr;
          end else if (served_q && !gstall) begin
            // Clear only once the served instruction actually leaves execute.
            served_q <= 1'b0;
          end
        end
        MemInd: if (bus.complete_data) state_q <= is_load(op_exec) ? MemRd : MemWr;
        MemRd, MemWr: begin
          if (bus.complete_data) begin
            state_q  <= MemIdle;
            served_q <= 1'b1;
          end
        end
        default: state_q <= MemIdle;
      endcase
      if (!hold) begin
        if (start_q != 2'd3) start_q <= start_q + 2'd1;
        if (trigger)              br_q <= BrLoad;
        else if (br_q != 2'd0)    br_q <= br_q - 2'd1;
      end
    end
  end

  assign bus.enable_updatePC  = en_pc;
  assign bus.enable_fetch     = en_f;
  assign bus.enable_decode    = en_d;
  assign bus.enable_execute   = en_e;
  assign bus.enable_writeback = en_w;
  assign bus.instrmem_rd      = en_f;
  assign bus.br_taken         = br_taken;
  assign bus.mem_state        = state_q;

  lc3_bypass_unit u_bypass (
    .en           (en_e),
    .ir           (bus.IR),
    .ir_exec      (bus.IR_Exec),
    .bypass_alu_1 (bus.bypass_alu_1),
    .bypass_alu_2 (bus.bypass_alu_2),
    .bypass_mem_1 (bus.bypass_mem_1),
    .bypass_mem_2 (bus.bypass_mem_2)
  );

  logic unused_imem;
  assign unused_imem = ^bus.IMem_dout[11:0];

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Bench for lc3_pipe_controller: directed scenarios plus a randomized run scored
// against an opcode-table reference model.
module tb_lc3_pipe_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lc3_pipe_controller_if bus ();

  lc3_pipe_controller #(.BR_BUBBLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Opcode class tables, one bit per opcode value.
  bit [15:0] alu_tab  = 16'h4222;
  bit [15:0] load_tab = 16'h0444;
  bit [15:0] st_tab   = 16'h0888;
  bit [15:0] ctrl_tab = 16'h1001;
  bit [15:0] sr1_tab  = 16'h12E2;

  // Reference model state.
  int m_mem    = 3;
  int m_start  = 0;
  int m_br     = 0;
  bit m_served = 1'b0;

  bit e_pc, e_f, e_d, e_e, e_w, e_bt, e_a1, e_a2, e_m1, e_m2, e_hold;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
            bus.enable_execute, bus.enable_writeback};
  endfunction

  task automatic model_eval();
    int op, ope, s2;
    bit [4:0] en;
    bit u1, u2, h1, h2;
    op  = int'(bus.IR[15:12]);
    ope = int'(bus.IR_Exec[15:12]);
    e_hold = (m_mem != 3) || !bus.complete_instr ||
             ((load_tab[ope] || st_tab[ope]) && !m_served);
    case (m_br)
      3:       en = {1'b0, 1'b0, 1'b0, 1'b1, m_start >= 3};
      2:       en = {1'b1, 1'b0, 1'b0, 1'b0, m_start >= 3};
      1:       en = 5'b11100;
      default: en = {1'b1, 1'b1, m_start >= 1, m_start >= 2, m_start >= 3};
    endcase
    if (e_hold) en = 5'b0;
    {e_pc, e_f, e_d, e_e, e_w} = en;
    u1 = sr1_tab[op];
    u2 = st_tab[op] || ((op == 1 || op == 5) && !bus.IR[5]);
    s2 = st_tab[op] ? int'(bus.IR[11:9]) : int'(bus.IR[2:0]);
    h1 = e_e && u1 && (int'(bus.IR[8:6]) == int'(bus.IR_Exec[11:9]));
    h2 = e_e && u2 && (s2 == int'(bus.IR_Exec[11:9]));
    e_a1 = h1 && alu_tab[ope];
    e_a2 = h2 && alu_tab[ope];
    e_m1 = h1 && load_tab[ope];
    e_m2 = h2 && load_tab[ope];
    e_bt = !e_hold && m_br == 2 &&
           (ope == 12 || (ope == 0 && (bus.IR_Exec[11:9] & bus.psr) != 3'b0));
  endtask

  task automatic model_edge();
    int ope;
    bit trig;
    if (reset) begin
      m_mem = 3; m_start = 0; m_br = 0; m_served = 1'b0;
      return;
    end
    model_eval();
    ope  = int'(bus.IR_Exec[15:12]);
    trig = e_f && bus.complete_instr && ctrl_tab[int'(bus.IMem_dout[15:12])];
    if (m_mem == 3) begin
      if ((load_tab[ope] || st_tab[ope]) && !m_served)
        m_mem = (ope == 10 || ope == 11) ? 1 : (load_tab[ope] ? 0 : 2);
      else if (m_served && bus.complete_instr)
        m_served = 1'b0;
    end else if (bus.complete_data) begin
      if (m_mem == 1) m_mem = load_tab[ope] ? 0 : 2;
      else begin m_mem = 3; m_served = 1'b1; end
    end
    if (!e_hold) begin
      if (m_start < 3) m_start++;
      if (trig) m_br = 3;
      else if (m_br > 0) m_br--;
    end
  endtask

  task automatic compare_all();
    model_eval();
    check_eq("en_updatePC",  bus.enable_updatePC,  e_pc);
    check_eq("en_fetch",     bus.enable_fetch,     e_f);
    check_eq("en_decode",    bus.enable_decode,    e_d);
    check_eq("en_execute",   bus.enable_execute,   e_e);
    check_eq("en_writeback", bus.enable_writeback, e_w);
    check_eq("instrmem_rd",  bus.instrmem_rd,      e_f);
    check_eq("br_taken",     bus.br_taken,         e_bt);
    check_eq("bypass_alu_1", bus.bypass_alu_1,     e_a1);
    check_eq("bypass_alu_2", bus.bypass_alu_2,     e_a2);
    check_eq("bypass_mem_1", bus.bypass_mem_1,     e_m1);
    check_eq("bypass_mem_2", bus.bypass_mem_2,     e_m2);
    check_eq("mem_state",    bus.mem_state,        16'(m_mem));
  endtask

  // Inputs are set just after a falling edge; outputs are compared, then the
  // model follows the DUT across the next rising edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  int ldi_cd [6] = '{0, 0, 0, 1, 1, 1};
  int ldi_ms [6] = '{3, 1, 1, 1, 0, 3};
  int str_ms [3] = '{3, 2, 3};
  bit [2:0] psr_list [2] = '{3'b010, 3'b100};

  initial begin
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b0;
    bus.IMem_dout      = 16'h1042;
    bus.IR             = 16'h0000;
    bus.IR_Exec        = 16'h1042;
    bus.psr            = 3'b000;
    reset = 1'b1;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b0;

    // Startup ramp.
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("startup_en", en_vec(), {1'b1, 1'b1, k >= 1, k >= 2, k >= 3});
      check_eq("startup_ms", bus.mem_state, 16'd3);
      tick();
    end

    // ALU forwarding.
    bus.IR_Exec = 16'h1283;
    bus.IR      = 16'h1440;
    #1;
    check_eq("byp_sr1", {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2},
             16'b1000);
    tick();
    bus.IR = 16'h1401;
    #1;
    check_eq("byp_sr2", {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2},
             16'b0100);
    tick();

    // LDI: indirect then read, pipeline frozen throughout.
    bus.IR      = 16'h1042;
    bus.IR_Exec = 16'hA200;
    for (int i = 0; i < 6; i++) begin
      bus.complete_data = ldi_cd[i][0];
      #1;
      check_eq("ldi_ms", bus.mem_state, 16'(ldi_ms[i]));
      check_eq("ldi_en", en_vec(), (i == 5) ? 16'h1f : 16'h0);
      tick();
    end
    bus.IR_Exec       = 16'h1042;
    bus.complete_data = 1'b0;
    tick();

    // STR with immediate completion.
    bus.IR_Exec       = 16'h7000;
    bus.complete_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("str_ms", bus.mem_state, 16'(str_ms[i]));
      check_eq("str_en", en_vec(), (i == 2) ? 16'h1f : 16'h0);
      tick();
    end
    bus.IR_Exec       = 16'h1042;
    bus.complete_data = 1'b0;
    tick();

    // BRz bubbles, taken then not taken.
    for (int p = 0; p < 2; p++) begin
      bus.psr       = psr_list[p];
      bus.IMem_dout = 16'h0402;
      bus.IR_Exec   = 16'h0402;
      #1;
      check_eq("br_t_en", en_vec(), 16'h1f);
      tick();
      bus.IMem_dout = 16'h1042;
      #1;
      check_eq("br_b1_en", en_vec(), 16'b00011);
      check_eq("br_b1_bt", bus.br_taken, 16'd0);
      tick();
      #1;
      check_eq("br_b2_en", en_vec(), 16'b10001);
      check_eq("br_b2_bt", bus.br_taken, (p == 0) ? 16'd1 : 16'd0);
      tick();
      #1;
      check_eq("br_b3_en", en_vec(), 16'b11100);
      check_eq("br_b3_bt", bus.br_taken, 16'd0);
      tick();
      #1;
      check_eq("br_done_en", en_vec(), 16'h1f);
      tick();
    end

    // Reset in the middle of an indirect access.
    bus.IR_Exec       = 16'hA200;
    bus.complete_data = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_pre_ms", bus.mem_state, 16'd1);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    bus.IR_Exec = 16'h1042;
    #1;
    check_eq("rst_ms", bus.mem_state, 16'd3);
    check_eq("rst_en", en_vec(), 16'b11000);
    tick();

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.complete_instr = ($urandom_range(7) != 0);
      bus.complete_data  = ($urandom_range(2) == 0);
      bus.IMem_dout      = 16'($urandom);
      bus.IR             = 16'($urandom);
      bus.IR_Exec        = 16'($urandom);
      bus.psr            = 3'($urandom);
      reset              = ($urandom_range(99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
